icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL expose parameter INDEX_BITS, default 7, log2 of the line count (128 direct-mapped lines, one 32-bit word per line).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rdy  input  1  low pauses fetch-side acceptance and response update.
REQ-005 SHALL have port req_valid  input  1  fetcher requests the word at req_addr.
REQ-006 SHALL have port req_addr  input  32  byte address; bits [1:0] ignored.
REQ-007 SHALL have port req_ready  output  1  request accepted at this edge when high with req_valid.
REQ-008 SHALL have port resp_valid  output  1  one-cycle pulse, resp_inst valid.
REQ-009 SHALL have port resp_inst  output  32  fetched instruction word.
REQ-010 SHALL have port cancel  input  1  jump/branch redirect; kill outstanding request.
REQ-011 SHALL have port inv_all  input  1  invalidate every line.
REQ-012 SHALL have port rw_flag  output  2  memory-controller command: 00 idle, 01 read.
REQ-013 SHALL have port mem_addr  output  32  word-aligned fill address.
REQ-014 SHALL have port len  output  2  access length code, bytes minus one (11 = 4 bytes).
REQ-015 SHALL have port read_data  input  32  fill data from memory controller.
REQ-016 SHALL have ports mem_busy, mem_done  input  1 each  controller busy level and one-cycle completion pulse.

Function
REQ-017 SHALL split address as tag = [31:2+INDEX_BITS], index = [1+INDEX_BITS:2].
REQ-018 SHALL implement FSM IDLE, FILL, RESP; req_ready = 1 only in IDLE with rdy=1 and cancel=0.
REQ-019 SHALL, on accepted request with valid matching tag at edge T, assert resp_valid with the line data at T+1 and stay IDLE (one hit per cycle sustained).
REQ-020 SHALL, on accepted miss at T, enter FILL at T+1 with rw_flag=01, mem_addr={req_addr[31:2],2'b00}, len=11, held constant until mem_done.
REQ-021 SHALL keep the read command asserted while mem_busy is high; mem_busy never aborts a fill.
REQ-022 SHALL, on mem_done at edge D in FILL, write tag/valid/data to the line, drive rw_flag=00 from D+1, and go to RESP.
REQ-023 SHALL in RESP assert resp_valid with resp_inst=read_data captured at D, then return to IDLE; RESP with rdy=0 holds until rdy=1.
REQ-024 SHALL treat cancel high at any edge as: no request accepted, any resp_valid scheduled for the next cycle suppressed; a fill in progress still completes and writes the line but produces no resp_valid (RESP skipped, straight to IDLE).
REQ-025 SHALL, on inv_all, clear all valid bits at that edge; a fill in flight at that time completes without setting valid, and its response is still delivered unless cancelled.
REQ-026 SHALL capture mem_done regardless of rdy; rdy=0 only blocks acceptance and RESP exit.
REQ-027 SHALL hold resp_inst stable when resp_valid=0.

Reset
REQ-028 SHALL on rst: state IDLE, all valid bits 0, resp_valid 0, resp_inst 0, rw_flag 00, mem_addr 0, len 00, cancel/drop flag 0; array data/tags need not reset.

Structure
REQ-029 SHALL place FSM state encodings, rw_flag codes (idle/read/write), len codes and address width in the shared defines header.
REQ-030 SHALL place tag/valid/data storage in one sub-module icache_array (single write port, single read port, bulk valid clear).

Verification
REQ-031 Cold miss: req 0x00000010 -> rw_flag=01, mem_addr 0x10, len 11; mem_done with 0x00A00093 -> resp_valid one cycle later, resp_inst 0x00A00093.
REQ-032 Hit: repeat req 0x10 -> resp_valid next cycle, rw_flag stays 00; back-to-back hits 0x10,0x14 (preloaded) -> two consecutive resp_valid pulses.
REQ-033 Conflict: fill 0x10, then req 0x210 (same index, INDEX_BITS=7) -> miss refill; subsequent 0x10 -> miss again.
REQ-034 Cancel mid-fill: miss 0x20, cancel during FILL -> no resp_valid; later req 0x20 -> hit with filled data.
REQ-035 inv_all after filling 0x10 -> next req 0x10 issues rw_flag=01; rst mid-FILL -> rw_flag 00 next cycle, all lines invalid.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: address width, FSM state
// encodings, memory-controller command codes and access length codes.
package icache_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Controller FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Memory-controller command codes carried on rw_flag
    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    // Access length codes: number of bytes minus one
    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b11;

    // Drop the byte offset so fills always start on a word boundary
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag / valid / data storage for the direct-mapped instruction cache.
// One asynchronous read port, one write port and a bulk valid clear.
// Only the valid bits are reset; tags and data are don't-care until valid.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = ADDR_W - 2 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_all,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  wr_valid,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_W-1:0]     wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [TAG_BITS-1:0] tag_d  [LINES];
    logic [DATA_W-1:0]   data_q [LINES];
    logic [DATA_W-1:0]   data_d [LINES];

    // Next valid bits: a bulk clear wins over a simultaneous line write
    always_comb begin
        valid_d = valid_q;
        if (clr_all) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_index] = wr_valid;
        end
    end

    // Valid bits are the only storage that must come out of reset cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Next tag/data contents: overwrite the addressed line on a write
    always_comb begin
        tag_d  = tag_q;
        data_d = data_q;
        if (wr_en) begin
            tag_d[wr_index]  = wr_tag;
            data_d[wr_index] = wr_data;
        end
    end

    // Tag and data storage, no reset needed since valid guards them
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits answer on the
// next cycle without leaving IDLE; misses issue a single word read to the
// memory controller, write the line on completion and then answer.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_inst,
    input  logic              cancel,
    input  logic              inv_all,
    output logic [1:0]        rw_flag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        len,
    input  logic [DATA_W-1:0] read_data,
    input  logic              mem_busy,
    input  logic              mem_done
);

    localparam int TAG_BITS = ADDR_W - 2 - INDEX_BITS;

    logic [1:0]        state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_inst_q, resp_inst_d;
    logic [1:0]        rw_flag_q, rw_flag_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        len_q, len_d;
    logic              drop_q, drop_d;
    logic              inv_q, inv_d;

    logic [INDEX_BITS-1:0] req_index, fill_index;
    logic [TAG_BITS-1:0]   req_tag, fill_tag;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [DATA_W-1:0]     rd_data;
    logic                  accept, hit;
    logic                  wr_en, wr_valid;

    // mem_busy never aborts a fill and the byte offset never selects
    // anything, so these bits are intentionally left without a consumer
    logic unused_inputs;
    assign unused_inputs = ^{mem_busy, req_addr[1:0]};

    assign req_index  = req_addr[INDEX_BITS+1:2];
    assign req_tag    = req_addr[ADDR_W-1:INDEX_BITS+2];
    assign fill_index = mem_addr_q[INDEX_BITS+1:2];
    assign fill_tag   = mem_addr_q[ADDR_W-1:INDEX_BITS+2];

    assign req_ready = (state_q == ST_IDLE) && rdy && !cancel;
    assign accept    = req_valid && req_ready;
    assign hit       = rd_valid && (rd_tag == req_tag);

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .clr_all  (inv_all),
        .rd_index (req_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (fill_index),
        .wr_valid (wr_valid),
        .wr_tag   (fill_tag),
        .wr_data  (read_data)
    );

    // Next-state logic: hit/miss decision, fill tracking and response timing
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_inst_d  = resp_inst_q;
        rw_flag_d    = rw_flag_q;
        mem_addr_d   = mem_addr_q;
        len_d        = len_q;
        drop_d       = drop_q;
        inv_d        = inv_q;
        wr_en        = 1'b0;
        wr_valid     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (hit) begin
                        resp_valid_d = 1'b1;
                        resp_inst_d  = rd_data;
                    end else begin
                        state_d    = ST_FILL;
                        rw_flag_d  = RW_READ;
                        mem_addr_d = word_align(req_addr);
                        len_d      = LEN_WORD;
                        drop_d     = 1'b0;
                        inv_d      = 1'b0;
                    end
                end
            end
            ST_FILL: begin
                if (cancel) begin
                    drop_d = 1'b1;
                end
                if (inv_all) begin
                    inv_d = 1'b1;
                end
                if (mem_done) begin
                    wr_en     = 1'b1;
                    wr_valid  = !(inv_q || inv_all);
                    rw_flag_d = RW_IDLE;
                    if (drop_q || cancel) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_inst_d  = read_data;
                    end
                end
            end
            ST_RESP: begin
                if (rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= '0;
            rw_flag_q    <= RW_IDLE;
            mem_addr_q   <= '0;
            len_q        <= LEN_BYTE;
            drop_q       <= 1'b0;
            inv_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_inst_q  <= resp_inst_d;
            rw_flag_q    <= rw_flag_d;
            mem_addr_q   <= mem_addr_d;
            len_q        <= len_d;
            drop_q       <= drop_d;
            inv_q        <= inv_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_inst  = resp_inst_q;
    assign rw_flag    = rw_flag_q;
    assign mem_addr   = mem_addr_q;
    assign len        = len_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a transaction-level cache model.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        cancel;
    logic        inv_all;
    logic [1:0]  rw_flag;
    logic [31:0] mem_addr;
    logic [1:0]  len;
    logic [31:0] read_data;
    logic        mem_busy;
    logic        mem_done;

    int unsigned nChecks = 0;
    int unsigned nFail   = 0;

    // Model: cache contents plus the one outstanding fill / pending response
    bit          mValid [128];
    logic [22:0] mTag   [128];
    logic [31:0] mData  [128];
    bit          mFill;
    bit          mWait;
    bit          mDrop;
    bit          mInv;
    logic [31:0] mFillAddr;
    bit          mRespValid;
    logic [31:0] mRespInst;

    icache dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_inst  (resp_inst),
        .cancel     (cancel),
        .inv_all    (inv_all),
        .rw_flag    (rw_flag),
        .mem_addr   (mem_addr),
        .len        (len),
        .read_data  (read_data),
        .mem_busy   (mem_busy),
        .mem_done   (mem_done)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic expReady();
        return !mFill && !mWait && rdy && !cancel;
    endfunction

    // Registered outputs against the model
    task automatic checkOutput();
        checkValue("resp_valid", {31'd0, resp_valid}, {31'd0, mRespValid});
        checkValue("resp_inst", resp_inst, mRespInst);
        checkValue("rw_flag", {30'd0, rw_flag}, mFill ? 32'd1 : 32'd0);
        if (mFill) begin
            checkValue("mem_addr", mem_addr, mFillAddr);
            checkValue("len", {30'd0, len}, 32'd3);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled
    task automatic modelUpdate();
        int unsigned idx;
        logic [22:0] tg;
        bit          nextResp;
        if (rst) begin
            mFill = 0; mWait = 0; mDrop = 0; mInv = 0;
            mRespValid = 0; mRespInst = 32'd0; mFillAddr = 32'd0;
            foreach (mValid[i]) mValid[i] = 0;
            return;
        end
        nextResp = 0;
        if (mFill) begin
            if (cancel)  mDrop = 1;
            if (inv_all) mInv = 1;
            if (mem_done) begin
                idx = (mFillAddr >> 2) % 128;
                mTag[idx]   = 23'(mFillAddr >> 9);
                mData[idx]  = read_data;
                mValid[idx] = !mInv;
                mFill = 0;
                if (!mDrop) begin
                    nextResp  = 1;
                    mRespInst = read_data;
                    mWait     = 1;
                end
            end
        end else if (mWait) begin
            if (rdy) mWait = 0;
        end else if (req_valid && rdy && !cancel) begin
            idx = (req_addr >> 2) % 128;
            tg  = 23'(req_addr >> 9);
            if (mValid[idx] && mTag[idx] == tg) begin
                nextResp  = 1;
                mRespInst = mData[idx];
            end else begin
                mFill     = 1;
                mDrop     = 0;
                mInv      = 0;
                mFillAddr = req_addr & 32'hFFFF_FFFC;
            end
        end
        if (inv_all) foreach (mValid[i]) mValid[i] = 0;
        mRespValid = nextResp;
    endtask

    // One clock: inputs already driven; check ready, clock, check outputs
    task automatic cycle();
        #1;
        checkValue("req_ready", {31'd0, req_ready}, {31'd0, expReady()});
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkOutput();
    endtask

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) begin
            a = $urandom();
        end else begin
            a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
        end
        return a;
    endfunction

    // Random inputs; the memory side only answers while a fill is expected
    task automatic applyStimulus();
        rst       = ($urandom_range(0, 199) == 0);
        rdy       = ($urandom_range(0, 99) < 85);
        cancel    = ($urandom_range(0, 99) < 5);
        inv_all   = ($urandom_range(0, 99) < 2);
        req_valid = ($urandom_range(0, 99) < 70);
        req_addr  = randAddr();
        mem_busy  = mFill;
        mem_done  = mFill && ($urandom_range(0, 99) < 35);
        read_data = $urandom();
    endtask

    task automatic reqOnce(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        cycle();
        req_valid = 1'b0;
    endtask

    task automatic finishFill(input logic [31:0] d);
        mem_busy  = 1'b1;
        mem_done  = 1'b1;
        read_data = d;
        cycle();
        mem_done  = 1'b0;
        mem_busy  = 1'b0;
    endtask

    // Directed scenarios, then random traffic, then the summary
    initial begin
        rst = 1'b1; rdy = 1'b1; req_valid = 1'b0; req_addr = 32'd0;
        cancel = 1'b0; inv_all = 1'b0; read_data = 32'd0;
        mem_busy = 1'b0; mem_done = 1'b0;
        repeat (2) @(posedge clk);
        modelUpdate();
        @(negedge clk);
        cycle();
        rst = 1'b0;
        checkValue("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkValue("rst_resp_inst", resp_inst, 32'd0);
        checkValue("rst_rw_flag", {30'd0, rw_flag}, 32'd0);
        checkValue("rst_mem_addr", mem_addr, 32'd0);
        checkValue("rst_len", {30'd0, len}, 32'd0);

        // Cold miss
        reqOnce(32'h0000_0010);
        checkValue("cold_rw_flag", {30'd0, rw_flag}, 32'd1);
        checkValue("cold_mem_addr", mem_addr, 32'h0000_0010);
        checkValue("cold_len", {30'd0, len}, 32'd3);
        mem_busy = 1'b1;
        cycle();
        cycle();
        checkValue("busy_hold_rw_flag", {30'd0, rw_flag}, 32'd1);
        finishFill(32'h00A0_0093);
        checkValue("cold_resp_valid", {31'd0, resp_valid}, 32'd1);
        checkValue("cold_resp_inst", resp_inst, 32'h00A0_0093);
        checkValue("cold_rw_idle", {30'd0, rw_flag}, 32'd0);
        cycle();
        checkValue("pulse_end", {31'd0, resp_valid}, 32'd0);
        checkValue("inst_hold", resp_inst, 32'h00A0_0093);

        // Hit, preload 0x14, then back-to-back hits
        reqOnce(32'h0000_0010);
        checkValue("hit_resp_valid", {31'd0, resp_valid}, 32'd1);
        checkValue("hit_rw_flag", {30'd0, rw_flag}, 32'd0);
        reqOnce(32'h0000_0014);
        cycle();
        finishFill(32'h1111_1111);
        cycle();
        req_valid = 1'b1; req_addr = 32'h0000_0010;
        cycle();
        checkValue("b2b_first", resp_inst, 32'h00A0_0093);
        req_addr = 32'h0000_0014;
        cycle();
        checkValue("b2b_second_valid", {31'd0, resp_valid}, 32'd1);
        checkValue("b2b_second", resp_inst, 32'h1111_1111);
        req_valid = 1'b0;
        cycle();

        // Conflict on index 4
        reqOnce(32'h0000_0210);
        checkValue("conflict_rw_flag", {30'd0, rw_flag}, 32'd1);
        checkValue("conflict_mem_addr", mem_addr, 32'h0000_0210);
        finishFill(32'h2222_2222);
        cycle();
        reqOnce(32'h0000_0010);
        checkValue("evicted_rw_flag", {30'd0, rw_flag}, 32'd1);
        finishFill(32'h00A0_0093);
        cycle();

        // Cancel mid-fill: no response, but the line is written
        reqOnce(32'h0000_0020);
        cancel = 1'b1;
        cycle();
        cancel = 1'b0;
        finishFill(32'h3333_3333);
        checkValue("cancel_no_resp", {31'd0, resp_valid}, 32'd0);
        cycle();
        reqOnce(32'h0000_0020);
        checkValue("cancel_hit_valid", {31'd0, resp_valid}, 32'd1);
        checkValue("cancel_hit_inst", resp_inst, 32'h3333_3333);

        // Invalidate all, then inv_all during a fill
        inv_all = 1'b1;
        cycle();
        inv_all = 1'b0;
        reqOnce(32'h0000_0010);
        checkValue("inv_miss_rw_flag", {30'd0, rw_flag}, 32'd1);
        finishFill(32'h00A0_0093);
        cycle();
        reqOnce(32'h0000_0040);
        inv_all = 1'b1;
        cycle();
        inv_all = 1'b0;
        finishFill(32'h4444_4444);
        checkValue("inv_fill_resp", resp_inst, 32'h4444_4444);
        cycle();
        reqOnce(32'h0000_0040);
        checkValue("inv_fill_not_valid", {30'd0, rw_flag}, 32'd1);
        finishFill(32'h4444_4444);
        cycle();

        // Reset in the middle of a fill
        reqOnce(32'h0000_0014);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checkValue("rst_fill_rw_flag", {30'd0, rw_flag}, 32'd0);
        reqOnce(32'h0000_0020);
        checkValue("rst_lines_invalid", {30'd0, rw_flag}, 32'd1);
        finishFill(32'h5555_5555);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            applyStimulus();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
